// File: rtl/opcode_encoder_pkg.sv
// Shared types and prefix map for the opcode encoder: opcode class, class prefixes, FSM states.
package opcode_enc_pkg;

    typedef enum logic [1:0] {
        ALU = 2'd0,
        LD  = 2'd1,
        ST  = 2'd2,
        BR  = 2'd3
    } op_class_e;

    localparam logic [4:0] PREFIX_ALU = 5'b11011;
    localparam logic [4:0] PREFIX_LD  = 5'b01011;
    localparam logic [4:0] PREFIX_ST  = 5'b10010;
    localparam logic [4:0] PREFIX_BR  = 5'b00111;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_e;

    function automatic logic [4:0] class_prefix(input op_class_e cls);
        logic [4:0] prefix;
        case (cls)
            ALU:     prefix = PREFIX_ALU;
            LD:      prefix = PREFIX_LD;
            ST:      prefix = PREFIX_ST;
            default: prefix = PREFIX_BR;
        endcase
        return prefix;
    endfunction

endpackage

// File: rtl/opcode_encoder_out_stage.sv
// Opcode output holding register: loads a new opcode, holds it under backpressure, clears after the final handshake.
// Optional even-parity output is enabled by OPCODE_ENCODER_PARITY_EN.
module opcode_out_stage #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [DATA_W-1:0] load_data,
    input  logic              load_last,
    input  logic              clear,
    output logic              op_valid,
    output logic [DATA_W-1:0] op_data,
`ifdef OPCODE_ENCODER_PARITY_EN
    output logic              op_parity,
`endif
    output logic              op_last
);

    // Load has priority so a new opcode can replace the one just handshaken in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_valid <= 1'b0;
            op_data  <= '0;
            op_last  <= 1'b0;
        end else if (load) begin
            op_valid <= 1'b1;
            op_data  <= load_data;
            op_last  <= load_last;
        end else if (clear) begin
            op_valid <= 1'b0;
            op_last  <= 1'b0;
        end
    end

`ifdef OPCODE_ENCODER_PARITY_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_parity <= 1'b0;
        end else if (load) begin
            op_parity <= ^load_data;
        end
    end
`endif

endmodule

// File: rtl/opcode_encoder.sv
// Command-to-opcode generator: turns {class, field, repeat} commands into bursts of {prefix, field} opcodes.
// Define OPCODE_ENCODER_PARITY_EN to add the op_parity output.
module opcode_encoder
    import opcode_enc_pkg::*;
#(
    parameter int FIELD_W  = 3,
    parameter int PREFIX_W = 5,
    parameter int REP_W    = 4,
    parameter int CNT_W    = 16
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         cmd_valid,
    output logic                         cmd_ready,
    input  logic [1:0]                   cmd_class,
    input  logic [FIELD_W-1:0]           cmd_field,
    input  logic [REP_W-1:0]             cmd_repeat,
    output logic                         op_valid,
    input  logic                         op_ready,
    output logic [PREFIX_W+FIELD_W-1:0]  op_data,
    output logic                         op_last,
`ifdef OPCODE_ENCODER_PARITY_EN
    output logic                         op_parity,
`endif
    output logic [CNT_W-1:0]             op_count
);

    localparam int DATA_W = PREFIX_W + FIELD_W;

    state_e            state;
    logic [REP_W-1:0]  remaining;
    logic              accept;
    logic              op_hs;
    logic              load;
    logic              load_last;
    logic              clear;
    logic [DATA_W-1:0] load_data;
    logic [PREFIX_W-1:0] cmd_prefix;

    // Both streams transfer on the cycle where valid && ready; a producer holds its payload until then.
    assign cmd_ready  = (state == IDLE) && (!op_valid || op_ready);
    assign accept     = cmd_valid && cmd_ready;
    assign op_hs      = op_valid && op_ready;
    assign cmd_prefix = PREFIX_W'(class_prefix(op_class_e'(cmd_class)));

    always_comb begin
        load      = 1'b0;
        load_last = 1'b0;
        clear     = 1'b0;
        load_data = '0;
        if (accept) begin
            load      = 1'b1;
            load_data = {cmd_prefix, cmd_field};
            load_last = (cmd_repeat == '0);
        end else if (state == BURST && op_hs) begin
            // Prefix is reused from the held opcode; only the low field steps and wraps.
            load      = 1'b1;
            load_data = {op_data[DATA_W-1:FIELD_W], op_data[FIELD_W-1:0] + FIELD_W'(1)};
            load_last = (remaining == REP_W'(1));
        end else if (op_hs) begin
            clear = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            remaining <= '0;
        end else if (accept) begin
            remaining <= cmd_repeat;
            state     <= (cmd_repeat != '0) ? BURST : IDLE;
        end else if (state == BURST && op_hs) begin
            remaining <= remaining - REP_W'(1);
            if (remaining == REP_W'(1)) begin
                state <= IDLE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_count <= '0;
        end else if (op_hs) begin
            op_count <= op_count + CNT_W'(1);
        end
    end

    opcode_out_stage #(
        .DATA_W (DATA_W)
    ) u_out_stage (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (load),
        .load_data (load_data),
        .load_last (load_last),
        .clear     (clear),
        .op_valid  (op_valid),
        .op_data   (op_data),
`ifdef OPCODE_ENCODER_PARITY_EN
        .op_parity (op_parity),
`endif
        .op_last   (op_last)
    );

endmodule

// File: tb/tb_opcode_encoder.sv
// Directed bench for opcode_encoder with hand-computed opcodes, burst, backpressure and async-reset cases.
module tb_opcode_encoder;

    logic        clk;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_class;
    logic [2:0]  cmd_field;
    logic [3:0]  cmd_repeat;
    logic        op_valid;
    logic        op_ready;
    logic [7:0]  op_data;
    logic        op_last;
    logic [15:0] op_count;
`ifdef OPCODE_ENCODER_PARITY_EN
    logic        op_parity;
`endif

    int tests_run;
    int tests_failed;

    opcode_encoder dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_class  (cmd_class),
        .cmd_field  (cmd_field),
        .cmd_repeat (cmd_repeat),
        .op_valid   (op_valid),
        .op_ready   (op_ready),
        .op_data    (op_data),
        .op_last    (op_last),
`ifdef OPCODE_ENCODER_PARITY_EN
        .op_parity  (op_parity),
`endif
        .op_count   (op_count)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_cmd(input logic [1:0] cls, input logic [2:0] field, input logic [3:0] rep);
        cmd_valid  = 1'b1;
        cmd_class  = cls;
        cmd_field  = field;
        cmd_repeat = rep;
    endtask

    task automatic check_op(input string tag, input logic [7:0] data, input logic last, input logic [15:0] cnt);
        check({tag, ".valid"}, 32'(op_valid), 32'd1);
        check({tag, ".data"},  32'(op_data),  32'(data));
        check({tag, ".last"},  32'(op_last),  32'(last));
        check({tag, ".count"}, 32'(op_count), 32'(cnt));
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst_n      = 1'b0;
        cmd_valid  = 1'b0;
        cmd_class  = 2'd0;
        cmd_field  = 3'd0;
        cmd_repeat = 4'd0;
        op_ready   = 1'b0;
        #12;
        check("rst.valid", 32'(op_valid), 32'd0);
        check("rst.data",  32'(op_data),  32'd0);
        check("rst.last",  32'(op_last),  32'd0);
        check("rst.count", 32'(op_count), 32'd0);
        check("rst.cmd_ready", 32'(cmd_ready), 32'd1);
`ifdef OPCODE_ENCODER_PARITY_EN
        check("rst.parity", 32'(op_parity), 32'd0);
`endif
        tick();
        rst_n = 1'b1;
        tick();

        // single ALU opcode, field 7
        op_ready = 1'b1;
        drive_cmd(2'd0, 3'd7, 4'd0);
        check("t1.cmd_ready", 32'(cmd_ready), 32'd1);
        tick();
        cmd_valid = 1'b0;
        check_op("t1", 8'hDF, 1'b1, 16'd0);
        check("t1.wildcard", 32'((op_data & 8'hF8) == 8'hD8), 32'd1);
`ifdef OPCODE_ENCODER_PARITY_EN
        check("t1.parity", 32'(op_parity), 32'd1);
`endif
        tick();
        check("t1.idle_valid", 32'(op_valid), 32'd0);
        check("t1.idle_count", 32'(op_count), 32'd1);

        // ALU burst from field 6, four beats with field wrap
        drive_cmd(2'd0, 3'd6, 4'd3);
        tick();
        cmd_valid = 1'b0;
        check_op("t2.b0", 8'hDE, 1'b0, 16'd1);
        check("t2.cmd_ready0", 32'(cmd_ready), 32'd0);
`ifdef OPCODE_ENCODER_PARITY_EN
        check("t2.parity", 32'(op_parity), 32'd0);
`endif
        tick();
        check_op("t2.b1", 8'hDF, 1'b0, 16'd2);
        check("t2.cmd_ready1", 32'(cmd_ready), 32'd0);
        tick();
        check_op("t2.b2", 8'hD8, 1'b0, 16'd3);
        tick();
        check_op("t2.b3", 8'hD9, 1'b1, 16'd4);
        check("t2.cmd_ready3", 32'(cmd_ready), 32'd1);
        tick();
        check("t2.idle_valid", 32'(op_valid), 32'd0);
        check("t2.idle_count", 32'(op_count), 32'd5);

        // LD burst under backpressure
        op_ready = 1'b0;
        drive_cmd(2'd1, 3'd0, 4'd1);
        tick();
        cmd_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check_op($sformatf("t3.hold%0d", i), 8'h58, 1'b0, 16'd5);
            check($sformatf("t3.cmd_ready%0d", i), 32'(cmd_ready), 32'd0);
            tick();
        end
        check_op("t3.hold3", 8'h58, 1'b0, 16'd5);
        op_ready = 1'b1;
        tick();
        check_op("t3.b1", 8'h59, 1'b1, 16'd6);
        tick();
        check("t3.idle_valid", 32'(op_valid), 32'd0);
        check("t3.idle_count", 32'(op_count), 32'd7);

        // back-to-back ST then BR
        drive_cmd(2'd2, 3'd2, 4'd0);
        tick();
        check_op("t4.st", 8'h92, 1'b1, 16'd7);
        drive_cmd(2'd3, 3'd5, 4'd0);
        check("t4.cmd_ready", 32'(cmd_ready), 32'd1);
        tick();
        cmd_valid = 1'b0;
        check_op("t4.br", 8'h3D, 1'b1, 16'd8);
        tick();
        check("t4.idle_valid", 32'(op_valid), 32'd0);
        check("t4.idle_count", 32'(op_count), 32'd9);

        // async reset in the middle of an ALU burst
        drive_cmd(2'd0, 3'd0, 4'd7);
        tick();
        cmd_valid = 1'b0;
        check_op("t5.b0", 8'hD8, 1'b0, 16'd9);
        tick();
        check_op("t5.b1", 8'hD9, 1'b0, 16'd10);
        tick();
        check_op("t5.b2", 8'hDA, 1'b0, 16'd11);
        #2;
        rst_n = 1'b0;
        #1;
        check("t5.rst_valid", 32'(op_valid), 32'd0);
        check("t5.rst_count", 32'(op_count), 32'd0);
        check("t5.rst_cmd_ready", 32'(cmd_ready), 32'd1);
        check("t5.rst_last", 32'(op_last), 32'd0);
        #1;
        rst_n = 1'b1;
        drive_cmd(2'd0, 3'd1, 4'd1);
        tick();
        cmd_valid = 1'b0;
        check_op("t5.new0", 8'hD9, 1'b0, 16'd0);
        tick();
        check_op("t5.new1", 8'hDA, 1'b1, 16'd1);
        tick();
        check("t5.idle_valid", 32'(op_valid), 32'd0);
        check("t5.idle_count", 32'(op_count), 32'd2);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
